// File: rtl/lsu_dccm_ctrl.sv
// Load/store front end for the DCCM: checks one request at a time, issues a
// single DCCM access, and returns an extended load result or an error response.
module lsu_dccm_ctrl #(
  parameter logic [31:0] DCCM_BASE      = 32'h0001_0000,
  parameter int unsigned DCCM_SIZE_LOG2 = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        dccm_wr_en,
  output logic        dccm_rd_en,
  output logic [31:0] dccm_wr_addr,
  output logic [31:0] dccm_rd_addr,
  output logic [31:0] dccm_wr_data,
  output logic [1:0]  store_type,
  output logic [1:0]  store_offset,
  input  logic [31:0] dccm_rd_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [32:0] WIN_BYTES = 33'd1 << DCCM_SIZE_LOG2;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] win_off;
  logic        out_of_win;
  logic        misaligned;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Window check is one unsigned compare, so addresses below the base wrap
  // to huge offsets and are rejected as well.
  always_comb begin
    win_off    = req_addr - DCCM_BASE;
    out_of_win = ({1'b0, win_off} >= WIN_BYTES);
    misaligned = (req_size == 2'd3)
               | ((req_size == 2'd1) & req_addr[0])
               | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
    req_err    = out_of_win | misaligned;
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = dccm_rd_data[7:0];
      2'd1:    ld_byte = dccm_rd_data[15:8];
      2'd2:    ld_byte = dccm_rd_data[23:16];
      default: ld_byte = dccm_rd_data[31:24];
    endcase
    ld_half = addr_q[1] ? dccm_rd_data[31:16] : dccm_rd_data[15:0];
    case (size_q)
      2'd0:    ld_ext = unsigned_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = unsigned_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = dccm_rd_data;
    endcase
  end

  // rdata/err only change on the edge that enters RESP and hold otherwise.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          if (req_err) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = 32'd0;
        end else begin
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = ld_ext;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Strobes come from the state register alone so reset kills them at once.
  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign dccm_wr_en   = (state_q == ACCESS) & we_q;
  assign dccm_rd_en   = (state_q == ACCESS) & ~we_q;
  assign dccm_wr_addr = {addr_q[31:2], 2'b00};
  assign dccm_rd_addr = {addr_q[31:2], 2'b00};
  assign dccm_wr_data = wdata_q;
  assign store_type   = size_q;
  assign store_offset = addr_q[1:0];

endmodule

// File: tb/tb_lsu_dccm_ctrl.sv
// Randomized self-checking bench for lsu_dccm_ctrl with a behavioural DCCM
// and a reference memory model that predicts every response.
module tb_lsu_dccm_ctrl;

   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam logic [31:0] WIN  = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqReady;
   logic        reqWe = 1'b0;
   logic [31:0] reqAddr = 32'd0;
   logic [31:0] reqWdata = 32'd0;
   logic [1:0]  reqSize = 2'd0;
   logic        reqUnsigned = 1'b0;
   logic        rspValid;
   logic        rspReady = 1'b0;
   logic [31:0] rspRdata;
   logic        rspErr;
   logic        dccmWrEn;
   logic        dccmRdEn;
   logic [31:0] dccmWrAddr;
   logic [31:0] dccmRdAddr;
   logic [31:0] dccmWrData;
   logic [1:0]  storeType;
   logic [1:0]  storeOffset;
   logic [31:0] dccmRdData = 32'd0;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] dccmMem [int];
   logic [31:0] refMem  [int];

   lsu_dccm_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (reqValid),
      .req_ready    (reqReady),
      .req_we       (reqWe),
      .req_addr     (reqAddr),
      .req_wdata    (reqWdata),
      .req_size     (reqSize),
      .req_unsigned (reqUnsigned),
      .rsp_valid    (rspValid),
      .rsp_ready    (rspReady),
      .rsp_rdata    (rspRdata),
      .rsp_err      (rspErr),
      .dccm_wr_en   (dccmWrEn),
      .dccm_rd_en   (dccmRdEn),
      .dccm_wr_addr (dccmWrAddr),
      .dccm_rd_addr (dccmRdAddr),
      .dccm_wr_data (dccmWrData),
      .store_type   (storeType),
      .store_offset (storeOffset),
      .dccm_rd_data (dccmRdData)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Untouched memory words hold a fixed scrambled pattern so both the DCCM
   // stand-in and the reference agree without having to preload anything.
   function automatic logic [31:0] initWord(input int key);
      logic [31:0] k;
      k = 32'(key);
      return (k * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic int wordKey(input logic [31:0] addr);
      logic [31:0] off;
      off = (addr - BASE) >> 2;
      return int'(off);
   endfunction

   // Byte/half/word merge of right-aligned store data into an old word.
   function automatic logic [31:0] mergeStore(input logic [31:0] oldWord,
                                              input logic [31:0] data,
                                              input logic [1:0] sizeCode,
                                              input logic [1:0] off);
      logic [31:0] mask;
      int          shamt;
      shamt = 8 * int'(off);
      if (sizeCode == 2'd0)
         mask = 32'h0000_00FF << shamt;
      else if (sizeCode == 2'd1)
         mask = 32'h0000_FFFF << shamt;
      else begin
         mask  = 32'hFFFF_FFFF;
         shamt = 0;
      end
      return (oldWord & ~mask) | ((data << shamt) & mask);
   endfunction

   // Behavioural single-cycle SRAM standing in for the DCCM.
   always @(posedge clk) begin
      if (dccmRdEn)
         dccmRdData <= dccmMem.exists(wordKey(dccmRdAddr)) ? dccmMem[wordKey(dccmRdAddr)]
                                                           : initWord(wordKey(dccmRdAddr));
      if (dccmWrEn)
         dccmMem[wordKey(dccmWrAddr)] = mergeStore(
            dccmMem.exists(wordKey(dccmWrAddr)) ? dccmMem[wordKey(dccmWrAddr)]
                                                : initWord(wordKey(dccmWrAddr)),
            dccmWrData, storeType, storeOffset);
   end

   function automatic logic [31:0] refRead(input logic [31:0] addr);
      int k;
      k = wordKey(addr);
      return refMem.exists(k) ? refMem[k] : initWord(k);
   endfunction

   // Expected load value: shift the addressed lane down, then extend it.
   function automatic logic [31:0] loadResult(input logic [31:0] word,
                                              input logic [31:0] addr,
                                              input logic [1:0] sizeCode,
                                              input bit uns);
      logic [31:0] sh;
      sh = word >> (8 * int'(addr[1:0]));
      if (sizeCode == 2'd0)
         return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      if (sizeCode == 2'd1)
         return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      return word;
   endfunction

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Runs one full request/response transaction and checks latency, DCCM
   // port activity, the response, and stability under backpressure.
   task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] sizeCode, input bit uns, input int hold);
      bit          expErr;
      int          expLat;
      logic [31:0] expData;
      int          lat;
      int          wrPulses;
      int          rdPulses;
      int          bothHigh;
      logic [31:0] wrAddr;
      logic [31:0] wrData;
      logic [1:0]  wrType;
      logic [1:0]  wrOff;
      logic [31:0] rdAddr;

      expErr = (sizeCode == 2'd3) || (sizeCode == 2'd1 && addr[0]) ||
               (sizeCode == 2'd2 && addr[1:0] != 2'b00) || ((addr - BASE) >= WIN);
      expLat  = expErr ? 1 : (we ? 2 : 3);
      expData = (expErr || we) ? 32'd0 : loadResult(refRead(addr), addr, sizeCode, uns);

      @(negedge clk);
      checkOutput("req_ready_idle", 32'(reqReady), 32'd1);
      reqValid    = 1'b1;
      reqWe       = we;
      reqAddr     = addr;
      reqWdata    = wdata;
      reqSize     = sizeCode;
      reqUnsigned = uns;
      rspReady    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reqValid = 1'b0;
      reqAddr  = $urandom();
      reqWdata = $urandom();

      lat = 1; wrPulses = 0; rdPulses = 0; bothHigh = 0;
      wrAddr = 32'd0; wrData = 32'd0; wrType = 2'd0; wrOff = 2'd0; rdAddr = 32'd0;
      while (!rspValid && lat < 8) begin
         if (dccmWrEn && dccmRdEn) bothHigh++;
         if (dccmWrEn) begin
            wrPulses++;
            wrAddr = dccmWrAddr; wrData = dccmWrData; wrType = storeType; wrOff = storeOffset;
         end
         if (dccmRdEn) begin
            rdPulses++;
            rdAddr = dccmRdAddr;
         end
         @(negedge clk);
         lat++;
      end

      checkOutput("latency", 32'(lat), 32'(expLat));
      checkOutput("both_strobes", 32'(bothHigh), 32'd0);
      checkOutput("wr_pulses", 32'(wrPulses), (!expErr && we) ? 32'd1 : 32'd0);
      checkOutput("rd_pulses", 32'(rdPulses), (!expErr && !we) ? 32'd1 : 32'd0);
      checkOutput("rsp_err", 32'(rspErr), 32'(expErr));
      checkOutput("rsp_rdata", rspRdata, expData);
      if (!expErr && we) begin
         checkOutput("wr_addr", wrAddr, {addr[31:2], 2'b00});
         checkOutput("wr_data", wrData, wdata);
         checkOutput("store_type", 32'(wrType), 32'(sizeCode));
         checkOutput("store_offset", 32'(wrOff), 32'(addr[1:0]));
         refMem[wordKey(addr)] = mergeStore(refRead(addr), wdata, sizeCode, addr[1:0]);
      end
      if (!expErr && !we)
         checkOutput("rd_addr", rdAddr, {addr[31:2], 2'b00});

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(rspValid), 32'd1);
         checkOutput("hold_rdata", rspRdata, expData);
         checkOutput("hold_err", 32'(rspErr), 32'(expErr));
         checkOutput("hold_req_ready", 32'(reqReady), 32'd0);
         checkOutput("hold_strobes", 32'({dccmWrEn, dccmRdEn}), 32'd0);
      end

      rspReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rspReady = 1'b0;
      checkOutput("post_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("post_req_ready", 32'(reqReady), 32'd1);
      checkOutput("post_rdata_held", rspRdata, expData);
   endtask

   // Main sequence: reset values, mid-load reset, directed cases, random mix.
   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          sel;

      repeat (2) @(negedge clk);
      checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("rst_rsp_rdata", rspRdata, 32'd0);
      checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
      checkOutput("rst_strobes", 32'({dccmWrEn, dccmRdEn}), 32'd0);
      checkOutput("rst_wr_addr", dccmWrAddr, 32'd0);
      checkOutput("rst_rd_addr", dccmRdAddr, 32'd0);
      checkOutput("rst_wr_data", dccmWrData, 32'd0);
      checkOutput("rst_type_off", 32'({storeType, storeOffset}), 32'd0);
      rst = 1'b0;

      @(negedge clk);
      reqValid = 1'b1; reqWe = 1'b0; reqAddr = BASE + 32'd4; reqSize = 2'd2; reqUnsigned = 1'b0;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      checkOutput("midload_rd_en", 32'(dccmRdEn), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_strobes", 32'({dccmWrEn, dccmRdEn}), 32'd0);
      checkOutput("midrst_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("midrst_req_ready", 32'(reqReady), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_idle_valid", 32'(rspValid), 32'd0);

      applyStimulus(1'b1, BASE + 32'd3, 32'h0000_00AB, 2'd0, 1'b0, 0);
      applyStimulus(1'b1, BASE, 32'h0000_8000, 2'd2, 1'b0, 0);
      applyStimulus(1'b0, BASE + 32'd1, 32'd0, 2'd0, 1'b0, 0);
      applyStimulus(1'b0, BASE + 32'd1, 32'd0, 2'd0, 1'b1, 0);
      applyStimulus(1'b1, BASE, 32'h8001_1234, 2'd2, 1'b0, 0);
      applyStimulus(1'b0, BASE + 32'd2, 32'd0, 2'd1, 1'b0, 0);
      applyStimulus(1'b0, BASE, 32'd0, 2'd2, 1'b0, 0);
      applyStimulus(1'b0, BASE + 32'd2, 32'd0, 2'd2, 1'b0, 0);
      applyStimulus(1'b1, BASE + 32'd1, 32'h0000_BEEF, 2'd1, 1'b0, 0);
      applyStimulus(1'b0, BASE + WIN, 32'd0, 2'd2, 1'b0, 0);
      applyStimulus(1'b1, BASE + WIN, 32'h1234_5678, 2'd0, 1'b0, 0);
      applyStimulus(1'b1, BASE + WIN - 32'd4, 32'hCAFE_F00D, 2'd2, 1'b0, 0);
      applyStimulus(1'b0, BASE + WIN - 32'd4, 32'd0, 2'd2, 1'b0, 0);
      applyStimulus(1'b0, BASE - 32'd1, 32'd0, 2'd0, 1'b1, 0);
      applyStimulus(1'b0, BASE + 32'd4, 32'd0, 2'd3, 1'b0, 0);
      applyStimulus(1'b0, BASE, 32'd0, 2'd2, 1'b0, 5);
      applyStimulus(1'b0, BASE + 32'd3, 32'd0, 2'd0, 1'b1, 0);

      for (int n = 0; n < 120; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel == 0)
            a = BASE + WIN - 32'd8 + 32'($urandom_range(0, 11));
         else if (sel == 1)
            a = BASE - 32'($urandom_range(1, 4));
         else if (sel == 2)
            a = $urandom();
         else
            a = BASE + 32'($urandom_range(0, 31));
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         applyStimulus(1'($urandom_range(0, 1)), a, $urandom(), sz,
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
